phase_accum: RTL
================

# phase_accum

Direct-digital-synthesis phase accumulator that generates the 16-bit phase address consumed by `sine_wave`. It advances a 24-bit phase once per sample tick by a frequency increment. New increments arrive over a valid/ready handshake and can be applied immediately (jump) or approached gradually (glide, for portamento). It also supports a note-on phase reset and flags each phase wrap.

## Interface
Parameters:
- `ACC_W`, 24: accumulator and increment width.
- `ADDR_W`, 16: phase address width; `o_addr` is `acc[ACC_W-1 -: ADDR_W]`.
- `GLIDE_SHIFT`, 4: glide step is `|target - cur| >> GLIDE_SHIFT`, with a minimum of 1.

Ports:
- `i_clk`, in, 1: single clock.
- `i_rst`, in, 1: reset; synchronous, active-high.
- `i_tick`, in, 1: sample-rate strobe; one-cycle pulses.
- `i_inc`, in, ACC_W: requested phase increment (unsigned).
- `i_inc_valid`, in, 1: `i_inc` is valid.
- `o_inc_ready`, out, 1: block accepts an increment; combinational, equals state IDLE.
- `i_glide`, in, 1: sampled with an accepted increment; 1 = glide, 0 = jump.
- `i_phase_rst`, in, 1: request to zero the phase on the next tick.
- `o_addr`, out, ADDR_W: phase address to `sine_wave`.
- `o_wrap`, out, 1: one-cycle pulse, accumulator carried out.
- `o_busy`, out, 1: glide in progress; equals state GLIDE.

## Operation
- Registers:
  - `acc` (ACC_W)
  - `cur_inc` (ACC_W)
  - `tgt_inc` (ACC_W)
  - `rst_pend` (1)
  - `state` {IDLE, GLIDE}
  - `o_wrap`
- Reset values, applied when `i_rst` is high at a clock edge:
  - `acc`, `cur_inc`, `tgt_inc` = 0; `rst_pend` = 0; `state` = IDLE.
  - Outputs: `o_wrap` = 0, `o_addr` = 0, `o_busy` = 0, `o_inc_ready` = 1.
  - `i_rst` overrides every other input in that cycle.
- Accumulate, on an edge with `i_tick` = 1:
  - If `rst_pend` = 1 or `i_phase_rst` = 1: `acc` <= 0, `o_wrap` <= 0, `rst_pend` <= 0.
  - Otherwise `{carry, acc}` <= `acc + cur_inc`, computed modulo 2^ACC_W, and `o_wrap` <= `carry`.
  - The add always uses the `cur_inc` value held before this edge.
- With no tick: `o_wrap` <= 0, and `rst_pend` <= `rst_pend | i_phase_rst`.
- Handshake: a transfer occurs when `i_inc_valid` & `o_inc_ready` at an edge. There is no buffering, so requests presented while GLIDE is active are not accepted.
- IDLE, on accept:
  - If `i_glide` = 0 or `i_inc == cur_inc`: `cur_inc` <= `i_inc`, stay IDLE.
  - Otherwise: `tgt_inc` <= `i_inc`, go to GLIDE.
- GLIDE, on each tick:
  - `d = |tgt_inc - cur_inc|`; `step = max(d >> GLIDE_SHIFT, 1)`.
  - `cur_inc` moves toward `tgt_inc` by `step`, computed without sign overflow. Because `step <= d`, it never overshoots.
  - If the new `cur_inc` equals `tgt_inc`, go to IDLE at the same edge.
- GLIDE with no tick: hold.
- `cur_inc` changes only on accept (in IDLE) or on a glide tick.
- Phase-reset coincident with a wrap: the reset wins and `o_wrap` stays 0.

## Timing
- `o_addr` is taken directly from the `acc` register bits. It reflects a tick one cycle after the `i_tick` edge, which gives `sine_wave` a full cycle of setup.
- Increment latency:
  - An increment accepted at edge N takes effect on the first tick strictly after N.
  - A tick at N itself uses the old `cur_inc`.
- `o_inc_ready`:
  - Falls in the cycle after a glide accept.
  - Rises in the cycle after the final glide tick.
- `o_wrap`: high for exactly the one cycle following the overflowing tick edge.
- Back-to-back ticks on every cycle are legal; all behaviour above holds at full rate.
- Reset mid-glide: the block returns to IDLE with `cur_inc` = 0. A pending phase reset is discarded.

## Test plan
- **Reset:** hold `i_rst` for 3 cycles with ticks and valid requests active → `o_addr` = 0x0000, `o_wrap` = 0, `o_busy` = 0, `o_inc_ready` = 1; no transfer is taken.
- **Jump and wrap:** accept `i_inc` = 0x010000 with `i_glide` = 0, then drive 256 ticks → `o_addr` steps 0x0100, 0x0200, … 0xFF00, then 0x0000 after tick 256, with `o_wrap` pulsing exactly once, in that cycle.
- **Glide up:** from `cur_inc` = 0, accept 0x000100 with `i_glide` = 1, then tick continuously:
  - First steps are 16, 15, 14, …; `cur_inc` is monotonic non-decreasing and never exceeds 0x100.
  - `o_busy` falls after `cur_inc` = 0x100.
  - `o_inc_ready` stays 0 throughout, and a valid held during the glide is accepted only after `o_busy` falls.
- **Glide down and equal-target:**
  - From 0x000100, glide to 0x000010 → monotonic decrease ending at exactly 0x10.
  - Accept 0x000010 again with `i_glide` = 1 → no GLIDE entry.
- **Phase reset:** at `acc` = 0xFFFF00 with inc 0x000200, assert `i_phase_rst` two cycles before a tick → after that tick `o_addr` = 0x0000 and `o_wrap` = 0; the next tick gives `o_addr` = 0x0002.
- **Coincidence:** accept a new increment on the same edge as a tick → that tick adds the old increment and the following tick adds the new one.

Source files
------------

// File: rtl/phase_accum.sv
// DDS phase accumulator: 24-bit phase advanced per sample tick, with jump/glide increment
// updates over a valid/ready handshake, note-on phase reset and a wrap pulse.
module phase_accum #(
  parameter int unsigned ACC_W       = 24,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned GLIDE_SHIFT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_tick,
  input  logic [ACC_W-1:0]  i_inc,
  input  logic              i_inc_valid,
  output logic              o_inc_ready,
  input  logic              i_glide,
  input  logic              i_phase_rst,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_wrap,
  output logic              o_busy
);

  typedef enum logic [0:0] {StIdle, StGlide} state_e;

  state_e           state_q;
  logic [ACC_W-1:0] acc_q, cur_inc_q, tgt_inc_q;
  logic             rst_pend_q, wrap_q;

  logic [ACC_W:0]   sum;
  logic             glide_up;
  logic [ACC_W-1:0] diff, step, glide_next;

  always_comb begin
    sum      = {1'b0, acc_q} + {1'b0, cur_inc_q};
    glide_up = tgt_inc_q > cur_inc_q;
    diff     = glide_up ? (tgt_inc_q - cur_inc_q) : (cur_inc_q - tgt_inc_q);
    step     = diff >> GLIDE_SHIFT;
    // Small gaps still converge one LSB per tick; step never exceeds diff.
    if (step == '0) step = ACC_W'(1);
    glide_next = glide_up ? (cur_inc_q + step) : (cur_inc_q - step);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      cur_inc_q  <= '0;
      tgt_inc_q  <= '0;
      rst_pend_q <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      if (i_tick) begin
        if (rst_pend_q || i_phase_rst) begin
          acc_q      <= '0;
          wrap_q     <= 1'b0;
          rst_pend_q <= 1'b0;
        end else begin
          acc_q  <= sum[ACC_W-1:0];
          wrap_q <= sum[ACC_W];
        end
      end else begin
        wrap_q     <= 1'b0;
        rst_pend_q <= rst_pend_q | i_phase_rst;
      end

      case (state_q)
        StIdle: begin
          if (i_inc_valid) begin
            if (!i_glide || (i_inc == cur_inc_q)) begin
              cur_inc_q <= i_inc;
            end else begin
              tgt_inc_q <= i_inc;
              state_q   <= StGlide;
            end
          end
        end
        StGlide: begin
          if (i_tick) begin
            cur_inc_q <= glide_next;
            if (glide_next == tgt_inc_q) state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_addr      = acc_q[ACC_W-1 -: ADDR_W];
  assign o_wrap      = wrap_q;
  assign o_busy      = (state_q == StGlide);
  assign o_inc_ready = (state_q == StIdle);

endmodule
